mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage RISC-V pipeline, directly downstream of the Execute stage.
- Contains the EX/MEM pipeline register, a request/acknowledge data-memory port FSM, store byte-lane alignment, load extraction with sign/zero extension, and the MEM/WB pipeline register.
- Supplies ALUResultM to the execute-stage forwarding muxes.
- Supplies StallM to the hazard unit.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- RegWriteE, MemWriteE  in  1 each  control bits from Execute.
- ResultSrcE  in  3  writeback select; 3'b001 marks a load.
- StoreSrcE  in  3  000 sw, 001 sh, 010 sb.
- LoadSrcE  in  3  000 lw, 001 lh, 010 lb, 011 lhu, 100 lbu.
- RdE  in  5  destination register.
- ALUResultE, WriteDataE, PCPlus4E  in  32 each  Execute results.
- FlushM  in  1  load a bubble into EX/MEM.
- DMemReq  out  1  memory request.
- DMemWe  out  1  write enable.
- DMemAddr  out  32  {ALUResultM[31:2],2'b00}.
- DMemBe  out  4  byte enables.
- DMemWdata  out  32  lane-aligned store data.
- DMemRdata  in  32  read word; valid when DMemAck=1.
- DMemAck  in  1  access complete.
- StallM  out  1  high while an access waits for DMemAck.
- ALUResultM  out  32  forwarding value.
- RegWriteW  out  1  MEM/WB register output.
- RdW  out  5  MEM/WB register output.
- ResultSrcW  out  3  MEM/WB register output.
- ALUResultW, ReadDataW, PCPlus4W  out  32 each  MEM/WB register outputs.

Behaviour:
- Reset:
  - All EX/MEM and MEM/WB registers clear to 0.
  - FSM goes to IDLE.
  - DMemReq, DMemWe, DMemBe and StallM are 0 immediately, including mid-access; the pending access is abandoned.
- Access definition: the M-stage instruction is an access when MemWriteM=1 or ResultSrcM=3'b001.
- FSM states:
  - IDLE: an access in M asserts DMemReq combinationally.
    - If DMemAck=1 in the same cycle, the access completes with 0 wait states and stays in IDLE.
    - Otherwise go to WAIT.
  - WAIT: DMemReq stays high and DMemAddr/DMemWe/DMemBe/DMemWdata stay stable until DMemAck.
    - On ack, return to IDLE.
- StallM = access & ~DMemAck. An ack on a non-access cycle is ignored.
- EX/MEM register:
  - When StallM=1, it holds.
  - Else, when FlushM=1, it loads a bubble: RegWrite=0, MemWrite=0, ResultSrc=0, others 0.
  - Else it captures the E inputs.
  - FlushM during a stall is ignored; the stall wins.
- MEM/WB register:
  - When StallM=1, it loads a bubble (RegWriteW=0).
  - Otherwise it captures the M values and the extended read data.
  - Load-to-W latency is 1 cycle after ack.
- Store alignment, with a = ALUResultM[1:0]:
  - sb: DMemBe = 1<<a; DMemWdata = byte replicated ×4.
  - sh: DMemBe = a[1] ? 1100 : 0011; DMemWdata = halfword replicated ×2.
  - sw: DMemBe = 1111.
  - Loads drive DMemBe=1111 and DMemWe=0.
- Load extraction: select byte a or halfword a[1] from DMemRdata, then sign-extend (lb/lh) or zero-extend (lbu/lhu). lw passes the word through.
- Unused LoadSrc encodings behave as lw. Unused StoreSrc encodings behave as sw.
- Non-access instructions pass through with a 1-cycle EX/MEM→MEM/WB latency; ReadDataW is 0.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- With the macro:
  - A misaligned access (sh/lh/lhu with a[0]=1, or sw/lw with a≠0) issues no DMemReq and never stalls.
  - The instruction enters MEM/WB with RegWriteW=0.
  - A 1-cycle output pulse MisalignW (1 bit, reset 0) is registered with it.
- Without the macro:
  - The MisalignW port is absent.
  - The low address bits are ignored for wider accesses (sw/lw use a=0, halfwords use a[1]) and the access proceeds normally.

Test Plan:
- Reset held, then released: all outputs are 0; after a mid-WAIT reset pulse, DMemReq drops in the same cycle without waiting for a clock edge.
- sb x=0x000000A5 at ALUResult 0x1003, ack same cycle -> DMemBe=1000, DMemWdata=0xA5A5A5A5, DMemAddr=0x1000, StallM=0.
- lb at 0x2001, DMemRdata=0x12348056, ack after 3 cycles -> StallM high for exactly 3 cycles; the W stage sees 3 bubbles then ReadDataW=0xFFFFFF80 with RegWriteW=1. lbu at the same address -> 0x00000080.
- lh at 0x2002, DMemRdata=0x8001FFFF -> ReadDataW=0xFFFF8001; lhu -> 0x00008001; lw -> 0x8001FFFF.
- FlushM=1 with a valid sw in E -> no DMemReq next cycle, and RegWriteW=0. FlushM asserted during WAIT -> the stalled store still completes.
- MISALIGN_TRAP_EN defined, sw at 0x3002 -> DMemReq stays 0, MisalignW=1 for one cycle, RegWriteW=0. Undefined -> DMemBe=1111 at DMemAddr 0x3000.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, req/ack data-memory port FSM, store lane alignment,
// load extension, MEM/WB register. Define MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic [2:0]      ResultSrcE,
  input  logic [2:0]      StoreSrcE,
  input  logic [2:0]      LoadSrcE,
  input  logic [4:0]      RdE,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic [XLEN-1:0] WriteDataE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic            FlushM,
  output logic            DMemReq,
  output logic            DMemWe,
  output logic [31:0]     DMemAddr,
  output logic [3:0]      DMemBe,
  output logic [31:0]     DMemWdata,
  input  logic [31:0]     DMemRdata,
  input  logic            DMemAck,
  output logic            StallM,
  output logic [XLEN-1:0] ALUResultM,
  output logic            RegWriteW,
  output logic [4:0]      RdW,
  output logic [2:0]      ResultSrcW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] PCPlus4W
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            MisalignW
`endif
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state_reg;

  logic        regwrite_m_reg, memwrite_m_reg;
  logic [2:0]  resultsrc_m_reg, storesrc_m_reg, loadsrc_m_reg;
  logic [4:0]  rd_m_reg;
  logic [31:0] alu_m_reg, wdata_m_reg, pcplus4_m_reg;

  logic        is_load, is_mem, byte_acc, half_acc, misalign, access;
  logic [1:0]  off;
  logic [3:0]  be_store;
  logic [31:0] shifted, load_ext, load_data;

  assign ALUResultM = alu_m_reg;
  assign is_load    = (resultsrc_m_reg == 3'b001);
  assign is_mem     = memwrite_m_reg | is_load;

  always_comb begin
    byte_acc = 1'b0;
    half_acc = 1'b0;
    if (memwrite_m_reg) begin
      byte_acc = (storesrc_m_reg == 3'b010);
      half_acc = (storesrc_m_reg == 3'b001);
    end else begin
      byte_acc = (loadsrc_m_reg == 3'b010) || (loadsrc_m_reg == 3'b100);
      half_acc = (loadsrc_m_reg == 3'b001) || (loadsrc_m_reg == 3'b011);
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign misalign = is_mem & ((half_acc & alu_m_reg[0]) |
                              (~byte_acc & ~half_acc & (alu_m_reg[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif
  assign access = is_mem & ~misalign;

  // Wider accesses ignore the address bits below their natural alignment.
  assign off = byte_acc ? alu_m_reg[1:0] : (half_acc ? {alu_m_reg[1], 1'b0} : 2'b00);

  always_comb begin
    be_store  = 4'b1111;
    DMemWdata = wdata_m_reg;
    if (byte_acc) begin
      be_store  = 4'b0001 << off;
      DMemWdata = {4{wdata_m_reg[7:0]}};
    end else if (half_acc) begin
      be_store  = 4'b0011 << off;
      DMemWdata = {2{wdata_m_reg[15:0]}};
    end
  end

  // Request is combinational in IDLE and held through WAIT; reset kills it at once.
  assign DMemReq  = (access | (state_reg == S_WAIT)) & ~reset;
  assign DMemWe   = DMemReq & memwrite_m_reg;
  assign DMemBe   = DMemReq ? (memwrite_m_reg ? be_store : 4'b1111) : 4'b0000;
  assign DMemAddr = {alu_m_reg[31:2], 2'b00};
  assign StallM   = access & ~DMemAck & ~reset;

  assign shifted = DMemRdata >> {off, 3'b000};
  always_comb begin
    case (loadsrc_m_reg)
      3'b010:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b011:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = DMemRdata;
    endcase
  end
  assign load_data = (is_load & ~misalign) ? load_ext : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  if (access && !DMemAck) state_reg <= S_WAIT;
        S_WAIT:  if (DMemAck) state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || (!StallM && FlushM)) begin
      regwrite_m_reg  <= 1'b0;
      memwrite_m_reg  <= 1'b0;
      resultsrc_m_reg <= 3'd0;
      storesrc_m_reg  <= 3'd0;
      loadsrc_m_reg   <= 3'd0;
      rd_m_reg        <= 5'd0;
      alu_m_reg       <= 32'd0;
      wdata_m_reg     <= 32'd0;
      pcplus4_m_reg   <= 32'd0;
    end else if (!StallM) begin
      regwrite_m_reg  <= RegWriteE;
      memwrite_m_reg  <= MemWriteE;
      resultsrc_m_reg <= ResultSrcE;
      storesrc_m_reg  <= StoreSrcE;
      loadsrc_m_reg   <= LoadSrcE;
      rd_m_reg        <= RdE;
      alu_m_reg       <= ALUResultE;
      wdata_m_reg     <= WriteDataE;
      pcplus4_m_reg   <= PCPlus4E;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || StallM) begin
      RegWriteW  <= 1'b0;
      RdW        <= 5'd0;
      ResultSrcW <= 3'd0;
      ALUResultW <= 32'd0;
      ReadDataW  <= 32'd0;
      PCPlus4W   <= 32'd0;
    end else begin
      RegWriteW  <= regwrite_m_reg & ~misalign;
      RdW        <= rd_m_reg;
      ResultSrcW <= resultsrc_m_reg;
      ALUResultW <= alu_m_reg;
      ReadDataW  <= load_data;
      PCPlus4W   <= pcplus4_m_reg;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) MisalignW <= 1'b0;
    else       MisalignW <= misalign & ~StallM;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a transaction-level model of the M stage, a word
// memory and a random-latency responder predict every memory-port and W-stage value.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteE, MemWriteE, FlushM;
  logic [2:0]  ResultSrcE, StoreSrcE, LoadSrcE;
  logic [4:0]  RdE;
  logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
  logic        DMemReq, DMemWe, DMemAck, StallM;
  logic [31:0] DMemAddr, DMemWdata, DMemRdata;
  logic [3:0]  DMemBe;
  logic [31:0] ALUResultM, ALUResultW, ReadDataW, PCPlus4W;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [2:0]  ResultSrcW;
`ifdef MISALIGN_TRAP_EN
  logic        MisalignW;
`endif

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .StoreSrcE(StoreSrcE), .LoadSrcE(LoadSrcE), .RdE(RdE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .FlushM(FlushM),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemBe(DMemBe),
    .DMemWdata(DMemWdata), .DMemRdata(DMemRdata), .DMemAck(DMemAck), .StallM(StallM),
    .ALUResultM(ALUResultM), .RegWriteW(RegWriteW), .RdW(RdW), .ResultSrcW(ResultSrcW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W)
`ifdef MISALIGN_TRAP_EN
    , .MisalignW(MisalignW)
`endif
  );

  typedef struct {
    logic rw, mw, fl;
    logic [2:0] rs, ss, ls;
    logic [4:0] rd;
    logic [31:0] alu, wd, pc4;
    int dly;
  } instr_t;

  typedef struct {
    logic rw;
    logic [4:0] rd;
    logic [2:0] rs;
    logic [31:0] alu, rdata, pc4;
    logic mis, chk_rd;
  } wb_t;

  instr_t dq[$];
  instr_t cur_e, m;
  wb_t    ew;
  int     waited;
  int     total = 0;
  int     bad = 0;
  logic [31:0] mem [logic [29:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic instr_t bubble();
    instr_t b;
    b = '{default: 0};
    return b;
  endfunction

  function automatic wb_t wb_zero();
    wb_t w;
    w = '{default: 0};
    w.chk_rd = 1'b1;
    return w;
  endfunction

  function automatic instr_t mk(logic rw, logic mw, logic [2:0] rs, logic [2:0] ss, logic [2:0] ls,
                                logic [31:0] alu, logic [31:0] wd, int dly, logic fl);
    instr_t i;
    i.rw = rw; i.mw = mw; i.rs = rs; i.ss = ss; i.ls = ls; i.alu = alu; i.wd = wd;
    i.dly = dly; i.fl = fl; i.rd = 5'($urandom); i.pc4 = $urandom;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    int k = $urandom_range(0, 2);
    logic fl = ($urandom_range(0, 9) == 0);
    logic [31:0] a = 32'h100 + 32'($urandom_range(0, 63));
    int d = $urandom_range(0, 3);
    if (k == 0)
      return mk(1'($urandom), 1'b0, ($urandom_range(0, 1) != 0) ? 3'b010 : 3'b000,
                3'($urandom), 3'($urandom), $urandom, $urandom, d, fl);
    else if (k == 1)
      return mk(1'b1, 1'b0, 3'b001, 3'($urandom), 3'($urandom_range(0, 7)), a, $urandom, d, fl);
    return mk(1'b0, 1'b1, 3'b000, 3'($urandom_range(0, 7)), 3'($urandom), a, $urandom, d, fl);
  endfunction

  function automatic instr_t next_instr();
    if (dq.size() > 0) return dq.pop_front();
    return rand_instr();
  endfunction

  function automatic int size_of(instr_t i);
    if (i.mw) return (i.ss == 3'd2) ? 1 : (i.ss == 3'd1) ? 2 : 4;
    return (i.ls == 3'd2 || i.ls == 3'd4) ? 1 : (i.ls == 3'd1 || i.ls == 3'd3) ? 2 : 4;
  endfunction

  function automatic bit is_mem(instr_t i);
    return i.mw || i.rs == 3'b001;
  endfunction

  function automatic bit misal(instr_t i);
`ifdef MISALIGN_TRAP_EN
    int sz = size_of(i);
    if (!is_mem(i)) return 0;
    if (sz == 2) return i.alu[0];
    if (sz == 4) return i.alu[1:0] != 2'b00;
`endif
    return 0;
  endfunction

  function automatic bit is_acc(instr_t i);
    return is_mem(i) && !misal(i);
  endfunction

  function automatic int off_of(instr_t i);
    int sz = size_of(i);
    int a = int'(i.alu[1:0]);
    if (sz == 1) return a;
    if (sz == 2) return a & 2;
    return 0;
  endfunction

  function automatic logic [31:0] rd_word(logic [31:0] addr);
    return mem.exists(addr[31:2]) ? mem[addr[31:2]] : 32'h0;
  endfunction

  function automatic logic [31:0] load_val(instr_t i, logic [31:0] word);
    int sz = size_of(i);
    logic [31:0] v = word >> (8 * off_of(i));
    logic [31:0] mask;
    if (sz == 4) return word;
    mask = (32'h1 << (8 * sz)) - 32'h1;
    v = v & mask;
    if ((i.ls == 3'd2 || i.ls == 3'd1) && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic wb_t wb_of(instr_t i, logic [31:0] word);
    wb_t w;
    w.rw = i.rw && !misal(i);
    w.rd = i.rd; w.rs = i.rs; w.alu = i.alu; w.pc4 = i.pc4;
    w.mis = misal(i);
    w.chk_rd = !i.mw;
    w.rdata = (i.rs == 3'b001 && !misal(i)) ? load_val(i, word) : 32'h0;
    return w;
  endfunction

  task automatic drive_e(instr_t i);
    RegWriteE = i.rw; MemWriteE = i.mw; ResultSrcE = i.rs; StoreSrcE = i.ss;
    LoadSrcE = i.ls; RdE = i.rd; ALUResultE = i.alu; WriteDataE = i.wd;
    PCPlus4E = i.pc4; FlushM = i.fl;
  endtask

  task automatic step();
    bit acc, stall;
    int sz, off;
    logic [31:0] word;
    logic [3:0] exp_be;
    @(negedge clk);
    chk("RegWriteW", 32'(RegWriteW), 32'(ew.rw));
    if (ew.rw || ew.chk_rd) chk("ReadDataW", ReadDataW, ew.rdata);
    if (ew.rw) begin
      chk("RdW", 32'(RdW), 32'(ew.rd));
      chk("ResultSrcW", 32'(ResultSrcW), 32'(ew.rs));
      chk("ALUResultW", ALUResultW, ew.alu);
      chk("PCPlus4W", PCPlus4W, ew.pc4);
    end
`ifdef MISALIGN_TRAP_EN
    chk("MisalignW", 32'(MisalignW), 32'(ew.mis));
`endif
    drive_e(cur_e);
    acc = is_acc(m);
    sz = size_of(m);
    off = off_of(m);
    word = rd_word(m.alu);
    if (acc) begin
      DMemAck = (waited >= m.dly);
      DMemRdata = m.mw ? $urandom : word;
    end else begin
      DMemAck = 1'($urandom);
      DMemRdata = $urandom;
    end
    #1;
    stall = acc && !DMemAck;
    chk("DMemReq", 32'(DMemReq), 32'(acc));
    chk("DMemWe", 32'(DMemWe), 32'(acc && m.mw));
    chk("StallM", 32'(StallM), 32'(stall));
    chk("ALUResultM", ALUResultM, m.alu);
    if (acc) begin
      exp_be = m.mw ? 4'(((1 << sz) - 1) << off) : 4'hF;
      chk("DMemBe", 32'(DMemBe), 32'(exp_be));
      chk("DMemAddr", DMemAddr, m.alu & ~32'h3);
      if (m.mw)
        chk("DMemWdata", DMemWdata, (sz == 1) ? m.wd[7:0] * 32'h01010101 :
                                    (sz == 2) ? m.wd[15:0] * 32'h00010001 : m.wd);
    end
    if (stall) begin
      ew = wb_zero();
      waited++;
    end else begin
      ew = wb_of(m, DMemRdata);
      if (acc && m.mw) begin
        for (int b = 0; b < sz; b++) word[8*(off+b) +: 8] = m.wd[8*b +: 8];
        mem[m.alu[31:2]] = word;
      end
      if (is_mem(m))
        $display("txn %s addr=%08h size=%0d wait=%0d mis=%0d", m.mw ? "st" : "ld",
                 m.alu, sz, waited, misal(m));
      m = cur_e.fl ? bubble() : cur_e;
      cur_e = next_instr();
      waited = 0;
    end
  endtask

  task automatic run_group();
    int guard = 0;
    while (dq.size() > 0 && guard < 200) begin
      step();
      guard++;
    end
    chk("drain", 32'(guard < 200), 32'd1);
    repeat (10) step();
  endtask

  initial begin
    reset = 1'b1;
    drive_e(bubble());
    DMemAck = 1'b0;
    DMemRdata = 32'h0;
    for (int k = 'h40; k < 'h50; k++) mem[30'(k)] = $urandom;
    repeat (3) @(negedge clk);
    chk("rst DMemReq", 32'(DMemReq), 0);
    chk("rst DMemWe", 32'(DMemWe), 0);
    chk("rst DMemBe", 32'(DMemBe), 0);
    chk("rst StallM", 32'(StallM), 0);
    chk("rst ALUResultM", ALUResultM, 0);
    chk("rst RegWriteW", 32'(RegWriteW), 0);
    chk("rst RdW", 32'(RdW), 0);
    chk("rst ResultSrcW", 32'(ResultSrcW), 0);
    chk("rst ALUResultW", ALUResultW, 0);
    chk("rst ReadDataW", ReadDataW, 0);
    chk("rst PCPlus4W", PCPlus4W, 0);
    m = bubble();
    ew = wb_zero();
    waited = 0;
    // A long load held in WAIT, then abandoned by a mid-cycle reset pulse.
    cur_e = mk(1'b1, 1'b0, 3'b001, 3'd0, 3'd0, 32'h104, 32'h0, 50, 1'b0);
    reset = 1'b0;
    repeat (3) step();
    chk("wait DMemReq", 32'(DMemReq), 1);
    reset = 1'b1;
    DMemAck = 1'b0;
    drive_e(bubble());
    #1;
    chk("midrst DMemReq", 32'(DMemReq), 0);
    chk("midrst StallM", 32'(StallM), 0);
    chk("midrst DMemBe", 32'(DMemBe), 0);
    chk("midrst DMemWe", 32'(DMemWe), 0);
    @(negedge clk);
    reset = 1'b0;
    m = bubble();
    ew = wb_zero();
    waited = 0;

    mem[30'h800] = 32'h12348056;
    dq.push_back(mk(1'b0, 1'b1, 3'b000, 3'b010, 3'd0, 32'h1003, 32'h000000A5, 0, 1'b0));
    dq.push_back(mk(1'b0, 1'b1, 3'b000, 3'b000, 3'd0, 32'h0124, 32'h11223344, 0, 1'b1));
    dq.push_back(mk(1'b0, 1'b1, 3'b000, 3'b001, 3'd0, 32'h0122, 32'hBEEF5678, 2, 1'b0));
    dq.push_back(mk(1'b1, 1'b0, 3'b001, 3'd0, 3'b000, 32'h0128, 32'h0, 0, 1'b1));
    dq.push_back(mk(1'b0, 1'b1, 3'b000, 3'b000, 3'd0, 32'h3002, 32'hCAFEF00D, 1, 1'b0));
    dq.push_back(mk(1'b1, 1'b0, 3'b001, 3'd0, 3'b010, 32'h2001, 32'h0, 3, 1'b0));
    dq.push_back(mk(1'b1, 1'b0, 3'b001, 3'd0, 3'b100, 32'h2001, 32'h0, 1, 1'b0));
    cur_e = next_instr();
    run_group();

    mem[30'h800] = 32'h8001FFFF;
    dq.push_back(mk(1'b1, 1'b0, 3'b001, 3'd0, 3'b001, 32'h2002, 32'h0, 2, 1'b0));
    dq.push_back(mk(1'b1, 1'b0, 3'b001, 3'd0, 3'b011, 32'h2002, 32'h0, 0, 1'b0));
    dq.push_back(mk(1'b1, 1'b0, 3'b001, 3'd0, 3'b000, 32'h2000, 32'h0, 1, 1'b0));
    run_group();

    repeat (400) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
